// File: rtl/round_timer_pkg.sv
// ============================================================================
// Module   : round_timer_pkg
// Purpose  : Shared state encoding and width helper for the round timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package round_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Bits needed to hold 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/round_timer_if.sv
// ============================================================================
// Module   : round_timer_if
// Purpose  : Control and status bundle between game controller and timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface round_timer_if #(
    parameter int TIMER_BITS = 6
) ();

    logic                  start;
    logic                  pause;
    logic                  load;
    logic [TIMER_BITS-1:0] load_value;
    logic [TIMER_BITS-1:0] current_time;
    logic                  running;
    logic                  warning;
    logic                  timer_done;
    logic                  done_pulse;

    modport master (
        output start, pause, load, load_value,
        input  current_time, running, warning, timer_done, done_pulse
    );

    modport slave (
        input  start, pause, load, load_value,
        output current_time, running, warning, timer_done, done_pulse
    );

endinterface

`default_nettype wire

// File: rtl/round_timer_tick_prescaler.sv
// ============================================================================
// Module   : tick_prescaler
// Purpose  : Divides clk by CLK_DIV, producing one tick per time unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler
    import round_timer_pkg::*;
#(
    parameter int CLK_DIV = 100_000_000
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clear,
    input  wire logic count_en,
    output logic      tick
);

    localparam int CW = clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST_M1 = CW'((CLK_DIV >= 2) ? (CLK_DIV - 2) : 0);
    localparam logic WRAP_AT_ZERO = (CLK_DIV <= 1);

    logic [CW-1:0] r_cnt;
    logic          r_wrap;

    // r_wrap is a registered copy of (r_cnt == CLK_DIV-1), so the tick
    // strobe comes straight from a flop and survives a pause unchanged.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt  <= '0;
            r_wrap <= WRAP_AT_ZERO;
        end else if (count_en) begin
            if (r_wrap) begin
                r_cnt  <= '0;
                r_wrap <= WRAP_AT_ZERO;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_wrap <= (r_cnt == LAST_M1);
            end
        end
    end

    assign tick = r_wrap & count_en;

endmodule

`default_nettype wire

// File: rtl/round_timer.sv
// ============================================================================
// Module   : round_timer
// Purpose  : Round countdown timer with prescaler, pause, warning and reload.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module round_timer
    import round_timer_pkg::*;
#(
    parameter int TIMER_BITS  = 6,
    parameter int MAX_TIME    = 30,
    parameter int WARN_TIME   = 5,
    parameter int CLK_DIV     = 100_000_000,
    parameter int AUTO_RELOAD = 0
) (
    input  wire logic    clk,
    input  wire logic    reset,
    round_timer_if.slave bus
);

    localparam logic [TIMER_BITS-1:0] MAX_VAL  = TIMER_BITS'(MAX_TIME);
    localparam logic [TIMER_BITS-1:0] WARN_VAL = TIMER_BITS'(WARN_TIME);
    localparam logic                  RELOAD   = (AUTO_RELOAD != 0);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [TIMER_BITS-1:0] r_time;
    logic [TIMER_BITS-1:0] w_time_nxt;
    logic [TIMER_BITS-1:0] r_reload;
    logic [TIMER_BITS-1:0] w_reload_nxt;
    logic                  r_pulse;
    logic                  w_pulse_nxt;
    logic                  w_pre_clear;
    logic                  w_tick;
    logic [TIMER_BITS-1:0] w_load_val;

    tick_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_pre_clear),
        .count_en (r_state == ST_RUN),
        .tick     (w_tick)
    );

    assign w_load_val = (bus.load_value == '0) ? MAX_VAL : bus.load_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_time   <= MAX_VAL;
            r_reload <= MAX_VAL;
            r_pulse  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_time   <= w_time_nxt;
            r_reload <= w_reload_nxt;
            r_pulse  <= w_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_time_nxt   = r_time;
        w_reload_nxt = r_reload;
        w_pulse_nxt  = 1'b0;
        w_pre_clear  = 1'b0;

        if (bus.load) begin
            w_reload_nxt = w_load_val;
            w_time_nxt   = w_load_val;
            w_state_nxt  = ST_IDLE;
            w_pre_clear  = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        w_pre_clear = 1'b1;
                        w_state_nxt = bus.pause ? ST_PAUSED : ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A tick landing with pause still counts; pause applies afterwards.
                    if (w_tick && (r_time != '0)) begin
                        if (r_time > 1) begin
                            w_time_nxt = r_time - 1'b1;
                        end else begin
                            w_pulse_nxt = 1'b1;
                            if (RELOAD) begin
                                w_time_nxt = r_reload;
                            end else begin
                                w_time_nxt  = '0;
                                w_state_nxt = ST_DONE;
                            end
                        end
                    end
                    if (bus.pause && (w_state_nxt == ST_RUN)) begin
                        w_state_nxt = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (!bus.pause) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (bus.start) begin
                        w_time_nxt  = r_reload;
                        w_pre_clear = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.current_time = r_time;
    assign bus.running      = (r_state == ST_RUN);
    assign bus.timer_done   = (r_state == ST_DONE);
    assign bus.done_pulse   = r_pulse;
    assign bus.warning      = ((r_state == ST_RUN) || (r_state == ST_PAUSED))
                              && (r_time != '0) && (r_time <= WARN_VAL);

endmodule

`default_nettype wire
